// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first.
// The per-bit full subtractor is two half subtractors plus an OR of their borrows.

// Half subtractor: diff = a ^ b, borrow = ~a & b.
module halfsub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_br;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d1;
  logic             w_br1;
  logic             w_d_bit;
  logic             w_br2;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

  // First stage: current operand bits.
  halfsub u_hs0 (
    .a      (r_a_sh[0]),
    .b      (r_b_sh[0]),
    .diff   (w_d1),
    .borrow (w_br1)
  );

  // Second stage: fold in the borrow carried from the previous bit.
  halfsub u_hs1 (
    .a      (w_d1),
    .b      (r_br),
    .diff   (w_d_bit),
    .borrow (w_br2)
  );

  assign w_br_next  = w_br1 | w_br2;
  assign w_res_next = {w_d_bit, r_res_sh[WIDTH-1:1]};

  // Control FSM and datapath; result registers only change on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_br     <= w_br_next;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            r_diff   <= w_res_next;
            r_borrow <= w_br_next;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy       = (r_state != StIdle);
  assign done       = (r_state == StDone);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes a - b one bit per clock, LSB first. The per-bit cell is a full subtractor built from two halfsub instances plus an OR gate, so this block consumes halfsub's diff/borrow outputs directly. It provides a start/busy/done handshake so an N-bit subtract costs a single 1-bit cell.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle pulse; diff/borrow_out are valid and newly updated
diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH
borrow_out  output  1  registered final borrow; 1 iff a < b (unsigned)

Behaviour:
- Per-bit cell:
  - hs0 = halfsub(a_bit, b_bit) gives d1, br1.
  - hs1 = halfsub(d1, br_reg) gives d_bit, br2.
  - br_next = br1 | br2.
  - halfsub port order is (a, b, diff, borrow).
- Internal registers: a_sh, b_sh, res_sh (WIDTH each), br_reg, cnt (clog2(WIDTH) bits), state.
- States: IDLE, SHIFT, DONE.
- Reset (async, any state, including mid-operation):
  - state=IDLE; all shift registers, br_reg and cnt = 0.
  - diff=0, borrow_out=0, done=0, busy=0.
  - Any operation in flight is discarded with no done pulse.
- IDLE:
  - On a clock edge with start=1: a_sh<=a, b_sh<=b, br_reg<=0, cnt<=0, state<=SHIFT.
  - start=0: remain in IDLE.
- SHIFT, on each edge:
  - res_sh <= {d_bit, res_sh[WIDTH-1:1]}; a_sh, b_sh shift right with 0 fill; br_reg <= br_next; cnt <= cnt+1.
  - When cnt==WIDTH-1: diff <= {d_bit, res_sh[WIDTH-1:1]}, borrow_out <= br_next, state <= DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- Timing: start accepted at edge k.
  - WIDTH SHIFT edges are k+1 .. k+WIDTH.
  - diff/borrow_out update at edge k+WIDTH; done is high between edges k+WIDTH and k+WIDTH+1.
  - busy is high from edge k to edge k+WIDTH+1.
  - Earliest next accept is edge k+WIDTH+2, giving a throughput of one op per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored: not queued, no effect on the operation in progress.
- a/b changes after the accepted edge have no effect; operands are captured once.
- diff/borrow_out hold their last result until the next completion; they are not cleared on start.
- Combinational outputs: busy and done decode from state only.
- Wrap-around: results are modulo 2^WIDTH; there is no signed interpretation.

Test Plan:
1. Assert rst for 2 cycles, then hold start=0 for 10 cycles -> diff=0, borrow_out=0, busy=0, done never high; assert rst mid-cycle (asynchronous) -> outputs zero immediately, no clock edge needed.
2. WIDTH=8, a=9, b=5, pulse start at edge k -> busy high from k, done high exactly one cycle after edge k+8, diff=8'h04, borrow_out=0.
3. Operand sweep, each with done at k+8:
   - a=8'h05, b=8'h09 -> diff=8'hFC, borrow_out=1.
   - a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0.
   - a=8'h00, b=8'hFF -> diff=8'h01, borrow_out=1.
4. Start 30 -> 10 at edge k, then pulse start with a=1, b=2 at k+3 and again in the DONE cycle; change a/b during busy -> result diff=8'd20, borrow_out=0; no second done; diff stays 20 for 5 idle cycles.
5. Hold start=1 continuously with a=100, b=1 -> done pulses every 10 cycles, diff=8'd99 each time, busy low exactly one cycle between ops.
6. Start a=50, b=60, assert rst at edge k+3 -> all outputs 0 at once, no done pulse; release rst, start a=7, b=3 -> diff=8'h04, borrow_out=0 after the normal 8+1 latency.
